// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported unified memory between instruction fetch and data access.
// Data normally wins; a waiting fetch is granted after MAX_D_STREAK consecutive data grants.
module mem_arbiter #(
    parameter int XLEN         = 32,
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [XLEN-1:0]   if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN/8-1:0] d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata,

    output logic              stall_if,
    output logic              stall_mem,
    output logic              busy
);

    localparam int                  BE_W       = XLEN / 8;
    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                drop_q, drop_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;

    always_comb begin
        // NOTE: every signal written here gets its default first, so no path can infer a latch.
        state_d     = state_q;
        drop_d      = drop_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (d_req && ((streak_q < STREAK_MAX) || !if_req)) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_be_d    = d_be;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    // The streak only counts data grants that actually made a fetch wait.
                    if (if_req) begin
                        if (streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        streak_d = '0;
                    end
                end else if (if_req) begin
                    state_d    = INST;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_be_d   = '0;
                    mem_addr_d = if_addr;
                    streak_d   = '0;
                end
            end
            DATA, INST: begin
                // A flushed fetch still runs to completion on the bus; only its ack is hidden.
                if ((state_q == INST) && if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    drop_d    = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            drop_q      <= drop_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Acks are combinational so the requester sees completion in the same cycle as mem_ack.
    assign d_ack    = mem_ack && (state_q == DATA);
    assign if_ack   = mem_ack && (state_q == INST) && !drop_q && !if_flush;
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    assign stall_if  = if_req && !if_ack;
    assign stall_mem = d_req && !d_ack;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected grants and read data,
// a negedge monitor pops and compares whenever the DUT grants or acks.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_t;

    logic              clk;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [XLEN-1:0]   if_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic              d_ack;
    logic [XLEN-1:0]   d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              busy;

    // Memory responder: automatic (latency mem_lat) or manual from the stimulus.
    logic        resp_en   = 1'b1;
    int          mem_lat   = 3;
    int          resp_cnt  = 0;
    logic        auto_ack  = 1'b0;
    logic [31:0] auto_rdata = '0;
    logic        man_ack   = 1'b0;
    logic [31:0] man_rdata = '0;
    logic [31:0] mem_img [logic [31:0]];

    assign mem_ack   = auto_ack | man_ack;
    assign mem_rdata = resp_en ? auto_rdata : man_rdata;

    grant_t      exp_grant[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_d[$];
    int          checks   = 0;
    int          failures = 0;

    mem_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_D_STREAK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_flush (if_flush),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_be   (mem_be),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return 32'h0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur within its cycle budget", name);
    endtask

    task automatic push_grant(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata);
        grant_t g;
        g.we    = we;
        g.be    = be;
        g.addr  = addr;
        g.wdata = wdata;
        exp_grant.push_back(g);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_d_ack(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!d_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!d_ack) fail_timeout(name);
    endtask

    task automatic wait_if_ack(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!if_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!if_ack) fail_timeout(name);
    endtask

    task automatic wait_mem_req(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_req && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!mem_req) fail_timeout(name);
    endtask

    task automatic wait_mem_ack(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!mem_ack && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!mem_ack) fail_timeout(name);
    endtask

    always @(posedge clk) begin
        #1;
        auto_ack = 1'b0;
        if (resp_en && rst && mem_req) begin
            resp_cnt++;
            if (resp_cnt > mem_lat) begin
                auto_ack   = 1'b1;
                auto_rdata = rd_word(mem_addr);
                resp_cnt   = 0;
            end
        end else begin
            resp_cnt = 0;
        end
    end

    // Monitor: grants, acks and requester-side protocol, all sampled at negedge.
    logic        mem_req_prev = 1'b0;
    logic        d_req_prev   = 1'b0;
    logic        d_ack_prev   = 1'b0;
    logic        if_req_prev  = 1'b0;
    logic        if_ack_prev  = 1'b0;
    logic        if_flush_prev = 1'b0;
    logic [68:0] d_fields_prev = '0;
    logic [31:0] if_addr_prev = '0;
    grant_t      mon_g;
    logic [31:0] mon_w;

    always @(negedge clk) begin
        if (mem_req && !mem_req_prev) begin
            if (exp_grant.size() == 0) begin
                failures++;
                $display("FAIL unexpected_grant: addr 0x%0h we %0b, none expected", mem_addr, mem_we);
            end else begin
                mon_g = exp_grant.pop_front();
                check("grant_we", mem_we, mon_g.we);
                check("grant_be", mem_be, mon_g.be);
                check("grant_addr", mem_addr, mon_g.addr);
                if (mon_g.we) check("grant_wdata", mem_wdata, mon_g.wdata);
            end
        end
        if (d_ack) begin
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL unexpected_d_ack: d_rdata 0x%0h, none expected", d_rdata);
            end else begin
                mon_w = exp_d.pop_front();
                check("d_rdata", d_rdata, mon_w);
            end
        end
        if (if_ack) begin
            if (exp_if.size() == 0) begin
                failures++;
                $display("FAIL unexpected_if_ack: if_rdata 0x%0h, none expected", if_rdata);
            end else begin
                mon_w = exp_if.pop_front();
                check("if_rdata", if_rdata, mon_w);
            end
        end
        if (!rst && (if_ack || d_ack)) begin
            failures++;
            $display("FAIL ack_in_reset: if_ack %0b d_ack %0b, required 0", if_ack, d_ack);
        end
        if (rst && d_req_prev && d_req && !d_ack_prev &&
            ({d_we, d_be, d_addr, d_wdata} != d_fields_prev)) begin
            failures++;
            $display("FAIL d_protocol: d_* changed before d_ack");
        end
        if (rst && if_req_prev && if_req && !if_ack_prev && !if_flush && !if_flush_prev &&
            (if_addr != if_addr_prev)) begin
            failures++;
            $display("FAIL if_protocol: if_addr changed before if_ack");
        end
        mem_req_prev  = mem_req;
        d_req_prev    = d_req;
        d_ack_prev    = d_ack;
        if_req_prev   = if_req;
        if_ack_prev   = if_ack;
        if_flush_prev = if_flush;
        d_fields_prev = {d_we, d_be, d_addr, d_wdata};
        if_addr_prev  = if_addr;
    end

    initial begin
        int n;
        rst      = 1'b1;
        if_req   = 1'b0;
        if_addr  = '0;
        if_flush = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_be     = '0;
        d_addr   = '0;
        d_wdata  = '0;

        mem_img[32'h0000_0020] = 32'h0000_0013;
        mem_img[32'h0000_0040] = 32'h0050_0093;
        mem_img[32'h0000_0044] = 32'h00A0_0113;
        mem_img[32'h0000_0048] = 32'h0010_8093;
        mem_img[32'h0000_0080] = 32'hBAD0_0080;
        mem_img[32'h0000_0200] = 32'h0000_0297;
        mem_img[32'h0000_0100] = 32'h1122_3344;
        mem_img[32'h0000_2000] = 32'hA0A0_0001;
        mem_img[32'h0000_2004] = 32'hA0A0_0002;
        mem_img[32'h0000_2008] = 32'hA0A0_0003;
        mem_img[32'h0000_200C] = 32'hA0A0_0004;
        mem_img[32'h0000_2010] = 32'hA0A0_0005;

        // 1: reset held with both requests and a stray mem_ack; data wins after release.
        #2 rst = 1'b0;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h100;
        if_req  = 1'b1;
        if_addr = 32'h20;
        man_ack = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 4'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_if_ack", if_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        man_ack = 1'b0;
        push_grant(1'b0, 4'hF, 32'h100, 32'h0);
        push_grant(1'b0, 4'h0, 32'h20, 32'h0);
        exp_d.push_back(32'h1122_3344);
        exp_if.push_back(32'h0000_0013);
        tick();
        rst = 1'b1;
        fork
            begin wait_d_ack("t1_d_ack", 30); tick(); d_req = 1'b0; end
            begin wait_if_ack("t1_if_ack", 40); tick(); if_req = 1'b0; end
        join

        // 2: single fetch, one-edge grant latency, stall_if until the ack.
        push_grant(1'b0, 4'h0, 32'h40, 32'h0);
        exp_if.push_back(32'h0050_0093);
        tick();
        if_req  = 1'b1;
        if_addr = 32'h40;
        @(negedge clk);
        check("t2_no_grant_yet", mem_req, 1'b0);
        @(negedge clk);
        check("t2_grant_latency", mem_req, 1'b1);
        check("t2_busy", busy, 1'b1);
        n = 0;
        while (!if_ack && n < 20) begin
            check("t2_stall_if", stall_if, 1'b1);
            @(negedge clk);
            n++;
        end
        if (!if_ack) fail_timeout("t2_if_ack");
        else check("t2_stall_released", stall_if, 1'b0);
        tick();
        if_req = 1'b0;

        // 3: store and fetch together: store first, one IDLE bubble, then fetch.
        push_grant(1'b1, 4'hF, 32'h1000, 32'hDEAD_BEEF);
        push_grant(1'b0, 4'h0, 32'h44, 32'h0);
        exp_d.push_back(32'h0);
        exp_if.push_back(32'h00A0_0113);
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_addr  = 32'h1000;
        d_wdata = 32'hDEAD_BEEF;
        if_req  = 1'b1;
        if_addr = 32'h44;
        @(negedge clk);
        check("t3_stall_mem", stall_mem, 1'b1);
        wait_d_ack("t3_d_ack", 20);
        check("t3_store_we", mem_we, 1'b1);
        check("t3_stall_mem_released", stall_mem, 1'b0);
        tick();
        d_req = 1'b0;
        d_we  = 1'b0;
        @(negedge clk);
        check("t3_bubble_req", mem_req, 1'b0);
        check("t3_bubble_busy", busy, 1'b0);
        @(negedge clk);
        check("t3_fetch_after_bubble", mem_req, 1'b1);
        wait_if_ack("t3_if_ack", 20);
        tick();
        if_req = 1'b0;

        // 4: data held back-to-back with a waiting fetch: 4 data, 1 fetch, data resumes.
        mem_lat = 0;
        for (int k = 0; k < 4; k++) begin
            push_grant(1'b0, 4'hF, 32'h2000 + 32'(4 * k), 32'h0);
            exp_d.push_back(32'hA0A0_0001 + 32'(k));
        end
        push_grant(1'b0, 4'h0, 32'h48, 32'h0);
        push_grant(1'b0, 4'hF, 32'h2010, 32'h0);
        exp_d.push_back(32'hA0A0_0005);
        exp_if.push_back(32'h0010_8093);
        tick();
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_be    = 4'hF;
        d_addr  = 32'h2000;
        d_wdata = 32'h0;
        if_req  = 1'b1;
        if_addr = 32'h48;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    wait_d_ack("t4_d_ack", 20);
                    tick();
                    if (k < 4) d_addr = 32'h2000 + 32'(4 * (k + 1));
                    else d_req = 1'b0;
                end
            end
            begin wait_if_ack("t4_if_ack", 40); tick(); if_req = 1'b0; end
        join

        // 5: flush one cycle after a fetch grant hides its ack; the refetch completes.
        mem_lat = 3;
        push_grant(1'b0, 4'h0, 32'h80, 32'h0);
        push_grant(1'b0, 4'h0, 32'h200, 32'h0);
        exp_if.push_back(32'h0000_0297);
        tick();
        if_req  = 1'b1;
        if_addr = 32'h80;
        wait_mem_req("t5_grant", 10);
        tick();
        if_flush = 1'b1;
        if_addr  = 32'h200;
        tick();
        if_flush = 1'b0;
        wait_mem_ack("t5_mem_ack", 20);
        check("t5_flushed_no_ack", if_ack, 1'b0);
        wait_if_ack("t5_refetch_ack", 30);
        tick();
        if_req = 1'b0;

        // 5b: flush in the very cycle of mem_ack also suppresses if_ack.
        resp_en = 1'b0;
        push_grant(1'b0, 4'h0, 32'h84, 32'h0);
        tick();
        if_req  = 1'b1;
        if_addr = 32'h84;
        wait_mem_req("t5b_grant", 10);
        tick();
        man_rdata = 32'h1234_5678;
        man_ack   = 1'b1;
        if_flush  = 1'b1;
        @(negedge clk);
        check("t5b_same_cycle_flush", if_ack, 1'b0);
        check("t5b_busy", busy, 1'b1);
        tick();
        man_ack  = 1'b0;
        if_flush = 1'b0;
        if_req   = 1'b0;
        @(negedge clk);
        check("t5b_back_to_idle", busy, 1'b0);

        // 6: reset during a data access aborts it; a late mem_ack gives no d_ack.
        push_grant(1'b0, 4'hF, 32'h3000, 32'h0);
        tick();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_be   = 4'hF;
        d_addr = 32'h3000;
        wait_mem_req("t6_grant", 10);
        #2 rst = 1'b0;
        #1;
        check("t6_abort_mem_req", mem_req, 1'b0);
        check("t6_abort_busy", busy, 1'b0);
        check("t6_abort_mem_addr", mem_addr, 32'h0);
        check("t6_abort_mem_be", mem_be, 4'h0);
        tick();
        d_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        man_rdata = 32'hCAFE_F00D;
        man_ack   = 1'b1;
        @(negedge clk);
        check("t6_late_ack_no_d_ack", d_ack, 1'b0);
        check("t6_late_ack_no_if_ack", if_ack, 1'b0);
        check("t6_late_ack_idle", busy, 1'b0);
        tick();
        man_ack = 1'b0;
        resp_en = 1'b1;

        repeat (3) tick();
        check("exp_grant_drained", 64'(exp_grant.size()), 64'd0);
        check("exp_if_drained", 64'(exp_if.size()), 64'd0);
        check("exp_d_drained", 64'(exp_d.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
